// File: rtl/ad7266_scan_ctrl.sv
// AD7266 channel sequencer: steps the mux address over the enabled channel mask,
// runs one conversion per channel and hands the packed A/B result pair downstream.
module ad7266_scan_ctrl #(
    parameter int SETUP_CYC   = 2,
    parameter int TIMEOUT_CYC = 64,
    parameter int NUM_CH      = 6
) (
    input  logic              SCLK,
    input  logic              rst_n,
    input  logic              i_enable,
    input  logic [NUM_CH-1:0] i_ch_mask,
    input  logic              i_range_sel,
    input  logic              i_diff_mode,
    input  logic [15:0]       i_interval,
    output logic              o_ad_go,
    input  logic              i_ad_done,
    input  logic [15:0]       i_ad_dataa,
    input  logic [15:0]       i_ad_datab,
    output logic [2:0]        o_a_sel,
    output logic              o_range,
    output logic              o_sgl_difn,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [31:0]       o_out_data,
    output logic              o_scan_done,
    output logic              o_timeout_err,
    output logic              o_busy,
    output logic [2:0]        o_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_CONV  = 3'd2,
        S_PUSH  = 3'd3,
        S_WAIT  = 3'd4
    } state_t;

    localparam logic [NUM_CH-1:0] DIFF_MASK = NUM_CH'(7);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [15:0]       r_cnt;
    logic [NUM_CH-1:0] r_mask;
    logic              r_range;
    logic              r_diff;
    logic [2:0]        r_ch;
    logic [31:0]       r_out_data;
    logic              r_scan_done;
    logic              r_timeout_err;

    logic [NUM_CH-1:0] w_eff_mask;
    logic [2:0]        w_first_ch;
    logic [2:0]        w_next_ch;
    logic              w_wrap;
    logic              w_start;
    logic              w_setup_end;
    logic              w_conv_tmo;
    logic              w_wait_end;
    logic              w_relatch;
    logic              w_unused;

    function automatic logic [2:0] lowest_ch(input logic [NUM_CH-1:0] mask);
        lowest_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i]) lowest_ch = 3'(i);
        end
    endfunction

    // Differential mode only has pairs on channels 0..2.
    assign w_eff_mask  = i_diff_mode ? (i_ch_mask & DIFF_MASK) : i_ch_mask;
    assign w_first_ch  = lowest_ch(w_eff_mask);
    assign w_start     = i_enable && (w_eff_mask != '0);
    assign w_setup_end = (r_cnt == 16'(SETUP_CYC - 1));
    assign w_conv_tmo  = (r_cnt == 16'(TIMEOUT_CYC - 1));
    assign w_wait_end  = (r_cnt == i_interval);
    assign w_unused    = &{1'b0, i_ad_dataa[15:12], i_ad_datab[15:12]};

    // Next higher set bit of the latched mask; wrap when none is left.
    always_comb begin
        w_wrap    = 1'b1;
        w_next_ch = lowest_ch(r_mask);
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (r_mask[i] && (3'(i) > r_ch)) begin
                w_next_ch = 3'(i);
                w_wrap    = 1'b0;
            end
        end
    end

    // A new scan re-samples mask/range/mode, either from IDLE or on wrap.
    assign w_relatch = ((r_state == S_IDLE) && w_start) ||
                       ((r_state == S_WAIT) && i_enable && w_wait_end && w_wrap && w_start);

    always_ff @(posedge SCLK or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_nxt = S_SETUP;
            S_SETUP: if (w_setup_end) w_state_nxt = S_CONV;
            S_CONV: begin
                if (i_ad_done)       w_state_nxt = S_PUSH;
                else if (w_conv_tmo) w_state_nxt = S_WAIT;
            end
            S_PUSH:  if (i_out_ready) w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (!i_enable)       w_state_nxt = S_IDLE;
                else if (w_wait_end) w_state_nxt = (w_wrap && !w_start) ? S_IDLE : S_SETUP;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output handshake: o_out_valid holds with o_out_data stable until a cycle in
    // which o_out_valid && i_out_ready; that cycle is the transfer.
    always_comb begin
        o_ad_go     = (r_state == S_CONV);
        o_out_valid = (r_state == S_PUSH);
        o_busy      = (r_state != S_IDLE);
        o_state     = r_state;
    end

    always_ff @(posedge SCLK or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_state_nxt != r_state) begin
            r_cnt <= '0;
        end else if ((r_state == S_SETUP) || (r_state == S_CONV) || (r_state == S_WAIT)) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    always_ff @(posedge SCLK or negedge rst_n) begin
        if (!rst_n) begin
            r_mask        <= '0;
            r_range       <= 1'b0;
            r_diff        <= 1'b0;
            r_ch          <= '0;
            r_out_data    <= '0;
            r_scan_done   <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_relatch) begin
                r_mask  <= w_eff_mask;
                r_range <= i_range_sel;
                r_diff  <= i_diff_mode;
                r_ch    <= w_first_ch;
            end else if ((r_state == S_WAIT) && i_enable && w_wait_end) begin
                r_ch <= w_next_ch;
            end
            if ((r_state == S_CONV) && i_ad_done) begin
                r_out_data <= {r_ch, 1'b0, i_ad_dataa[11:0], r_ch, 1'b1, i_ad_datab[11:0]};
            end
            // Only an accepted word on the last channel completes a scan.
            r_scan_done <= (r_state == S_PUSH) && i_out_ready && w_wrap;
            if ((r_state == S_CONV) && !i_ad_done && w_conv_tmo) r_timeout_err <= 1'b1;
            else if (!i_enable)                                 r_timeout_err <= 1'b0;
        end
    end

    assign o_a_sel       = r_ch;
    assign o_range       = r_range;
    assign o_sgl_difn    = ~r_diff;
    assign o_out_data    = r_out_data;
    assign o_scan_done   = r_scan_done;
    assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_ad7266_scan_ctrl.sv
// Directed bench for ad7266_scan_ctrl: an ADC responder model answers ad_go, a negedge
// monitor records conversions and accepted words, and each scenario checks them.
module tb_ad7266_scan_ctrl;

    localparam int SETUP_CYC   = 2;
    localparam int TIMEOUT_CYC = 64;
    localparam int CONV_DLY    = 16;

    logic        SCLK = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [5:0]  ch_mask;
    logic        range_sel;
    logic        diff_mode;
    logic [15:0] interval;
    logic        ad_go;
    logic        ad_done;
    logic [15:0] ad_dataa;
    logic [15:0] ad_datab;
    logic [2:0]  a_sel;
    logic        range;
    logic        sgl_difn;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        scan_done;
    logic        timeout_err;
    logic        busy;
    logic [2:0]  state;

    logic [15:0] da [0:7];
    logic [15:0] db [0:7];
    logic [5:0]  resp_en;
    int          go_cnt;

    int          n_checks = 0;
    int          n_err    = 0;
    int          pcyc     = 0;
    logic [31:0] exp_q [$];
    logic [31:0] got_q [$];
    int          acc_q [$];
    int          go_rise_q [$];
    int          go_len_q [$];
    int          sd_q [$];
    logic [2:0]  asel_q [$];
    logic        rng_q [$];
    logic        sgl_q [$];
    int          done_cyc = 0;
    int          vrise_cyc = 0;
    int          go_len = 0;
    logic        go_prev = 1'b0;
    logic        val_prev = 1'b0;
    int          t0;
    int          ok;

    ad7266_scan_ctrl #(.SETUP_CYC(SETUP_CYC), .TIMEOUT_CYC(TIMEOUT_CYC), .NUM_CH(6)) dut (
        .SCLK(SCLK), .rst_n(rst_n), .i_enable(enable), .i_ch_mask(ch_mask),
        .i_range_sel(range_sel), .i_diff_mode(diff_mode), .i_interval(interval),
        .o_ad_go(ad_go), .i_ad_done(ad_done), .i_ad_dataa(ad_dataa), .i_ad_datab(ad_datab),
        .o_a_sel(a_sel), .o_range(range), .o_sgl_difn(sgl_difn), .o_out_valid(out_valid),
        .i_out_ready(out_ready), .o_out_data(out_data), .o_scan_done(scan_done),
        .o_timeout_err(timeout_err), .o_busy(busy), .o_state(state)
    );

    always #5 SCLK = ~SCLK;
    always @(posedge SCLK) pcyc++;

    // ADC model: ad_done comes CONV_DLY cycles after ad_go rises, for enabled channels only.
    initial begin
        ad_done  = 1'b0;
        ad_dataa = 16'hDEAD;
        ad_datab = 16'hDEAD;
        go_cnt   = 0;
        forever begin
            @(posedge SCLK);
            #1;
            ad_done  = 1'b0;
            ad_dataa = 16'hDEAD;
            ad_datab = 16'hDEAD;
            if (ad_go && resp_en[a_sel]) begin
                if (go_cnt == CONV_DLY) begin
                    ad_done  = 1'b1;
                    ad_dataa = da[a_sel];
                    ad_datab = db[a_sel];
                    go_cnt   = 0;
                end else begin
                    go_cnt++;
                end
            end else begin
                go_cnt = 0;
            end
        end
    end

    always @(negedge SCLK) begin
        if (!rst_n) begin
            go_prev  = 1'b0;
            val_prev = 1'b0;
            go_len   = 0;
        end else begin
            if (out_valid && out_ready) begin
                got_q.push_back(out_data);
                acc_q.push_back(pcyc);
            end
            if (ad_go && !go_prev) begin
                go_rise_q.push_back(pcyc);
                asel_q.push_back(a_sel);
                rng_q.push_back(range);
                sgl_q.push_back(sgl_difn);
            end
            if (ad_go) go_len++;
            else if (go_prev) begin
                go_len_q.push_back(go_len);
                go_len = 0;
            end
            if (ad_go && ad_done) done_cyc = pcyc;
            if (out_valid && !val_prev) vrise_cyc = pcyc;
            if (scan_done) sd_q.push_back(got_q.size());
            go_prev  = ad_go;
            val_prev = out_valid;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge SCLK);
            #1;
        end
    endtask

    task automatic wait_words(input string tag, input int n, input int budget);
        int k = 0;
        while (got_q.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        check(tag, 32'(got_q.size() >= n), 32'd1);
    endtask

    task automatic stop_scan(input string tag);
        int k = 0;
        enable = 1'b0;
        while (busy && k < 400) begin
            tick(1);
            k++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic clear_q;
        exp_q.delete(); got_q.delete(); acc_q.delete(); go_rise_q.delete();
        go_len_q.delete(); sd_q.delete(); asel_q.delete(); rng_q.delete(); sgl_q.delete();
    endtask

    task automatic check_words(input string tag);
        check({tag, "_count"}, 32'(got_q.size() >= exp_q.size()), 32'd1);
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("%s_word%0d", tag, i), got_q[i], exp_q[i]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; enable = 1'b0; ch_mask = '0; range_sel = 1'b0; diff_mode = 1'b0;
        interval = '0; out_ready = 1'b1; resp_en = 6'h3F;
        for (int i = 0; i < 8; i++) begin
            da[i] = 16'h0;
            db[i] = 16'h0;
        end
        tick(3);
        check("rst_ad_go",     32'(ad_go),       32'd0);
        check("rst_a_sel",     32'(a_sel),       32'd0);
        check("rst_range",     32'(range),       32'd0);
        check("rst_sgl_difn",  32'(sgl_difn),    32'd1);
        check("rst_out_valid", 32'(out_valid),   32'd0);
        check("rst_out_data",  out_data,         32'd0);
        check("rst_scan_done", 32'(scan_done),   32'd0);
        check("rst_tmo_err",   32'(timeout_err), 32'd0);
        check("rst_busy",      32'(busy),        32'd0);
        check("rst_state",     32'(state),       32'd0);
        rst_n = 1'b1;
        tick(2);

        // Differential mode masks channels 3..5 away: nothing to scan.
        diff_mode = 1'b1; ch_mask = 6'b111000; enable = 1'b1;
        tick(5);
        check("empty_mask_idle", 32'(busy), 32'd0);
        enable = 1'b0; diff_mode = 1'b0;
        tick(2);

        // Single channel, interval 0.
        da[0] = 16'h0ABC; db[0] = 16'h0123; ch_mask = 6'b000001;
        enable = 1'b1; t0 = pcyc;
        wait_words("t1_wait", 3, 300);
        stop_scan("t1_stop");
        repeat (3) exp_q.push_back(32'h0ABC_1123);
        check_words("t1");
        check("t1_a_sel",        32'(asel_q[0]),                  32'd0);
        check("t1_start_lat",    32'(go_rise_q[0] - t0),          32'(SETUP_CYC + 1));
        check("t1_go_len",       32'(go_len_q[0]),                32'(CONV_DLY + 1));
        check("t1_valid_lat",    32'(vrise_cyc - done_cyc),       32'd1);
        check("t1_period",       32'(go_rise_q[1] - go_rise_q[0]), 32'(SETUP_CYC + CONV_DLY + 3));
        check("t1_accept_to_go", 32'(go_rise_q[1] - acc_q[0]),    32'd4);
        check("t1_scan_done_n",  32'(sd_q.size()),                32'd3);
        clear_q();

        // Sparse mask 101010.
        da[1] = 16'hF111; db[1] = 16'h8222; da[3] = 16'hF333; db[3] = 16'h7444;
        da[5] = 16'hF555; db[5] = 16'h6666; ch_mask = 6'b101010;
        enable = 1'b1;
        wait_words("t2_wait", 4, 400);
        stop_scan("t2_stop");
        exp_q.push_back(32'h2111_3222); exp_q.push_back(32'h6333_7444);
        exp_q.push_back(32'hA555_B666); exp_q.push_back(32'h2111_3222);
        check_words("t2");
        check("t2_asel0", 32'(asel_q[0]), 32'd1);
        check("t2_asel1", 32'(asel_q[1]), 32'd3);
        check("t2_asel2", 32'(asel_q[2]), 32'd5);
        check("t2_asel3", 32'(asel_q[3]), 32'd1);
        check("t2_sd_n",  32'(sd_q.size()), 32'd1);
        check("t2_sd_at", 32'(sd_q[0]),     32'd3);
        clear_q();

        // Differential mode, full mask; range_sel changes mid-scan.
        da[0] = 16'h1234; db[0] = 16'h5678; da[2] = 16'hFCDE; db[2] = 16'hF0F0;
        diff_mode = 1'b1; ch_mask = 6'b111111; range_sel = 1'b1;
        enable = 1'b1;
        ok = 0;
        while (go_rise_q.size() < 1 && ok < 50) begin
            tick(1);
            ok++;
        end
        range_sel = 1'b0;
        wait_words("t3_wait", 4, 400);
        stop_scan("t3_stop");
        exp_q.push_back(32'h0234_1678); exp_q.push_back(32'h2111_3222);
        exp_q.push_back(32'h4CDE_50F0); exp_q.push_back(32'h0234_1678);
        check_words("t3");
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t3_asel%0d", i), 32'(asel_q[i]), 32'(i % 3));
            check($sformatf("t3_sgl%0d", i),  32'(sgl_q[i]),  32'd0);
            check($sformatf("t3_rng%0d", i),  32'(rng_q[i]),  (i < 3) ? 32'd1 : 32'd0);
        end
        diff_mode = 1'b0;
        clear_q();

        // Channel 0 never answers: timeout, skip, channel 1 proceeds.
        resp_en = 6'b111110; ch_mask = 6'b000011;
        enable = 1'b1;
        wait_words("t4_wait", 1, 400);
        check("t4_words",   32'(got_q.size()),  32'd1);
        check("t4_word",    got_q[0],           32'h2111_3222);
        check("t4_go_len",  32'(go_len_q[0]),   32'(TIMEOUT_CYC));
        check("t4_asel0",   32'(asel_q[0]),     32'd0);
        check("t4_asel1",   32'(asel_q[1]),     32'd1);
        check("t4_err_set", 32'(timeout_err),   32'd1);
        enable = 1'b0;
        tick(1);
        enable = 1'b1;
        check("t4_err_clr", 32'(timeout_err), 32'd0);
        stop_scan("t4_stop");
        resp_en = 6'h3F;
        clear_q();

        // Downstream stall of 50 cycles.
        ch_mask = 6'b000100; out_ready = 1'b0;
        enable = 1'b1;
        ok = 0;
        while (!out_valid && ok < 100) begin
            tick(1);
            ok++;
        end
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            if (out_valid && out_data == 32'h4CDE_50F0 && !ad_go && state == 3'd3) ok++;
        end
        check("t5_stall_stable", 32'(ok), 32'd50);
        check("t5_no_new_conv",  32'(go_rise_q.size()), 32'd1);
        out_ready = 1'b1;
        tick(1);
        check("t5_first_ready_accept", 32'(got_q.size()), 32'd1);
        check("t5_valid_drop",         32'(out_valid),    32'd0);
        wait_words("t5_wait", 2, 200);
        stop_scan("t5_stop");
        exp_q.push_back(32'h4CDE_50F0); exp_q.push_back(32'h4CDE_50F0);
        check_words("t5");
        clear_q();

        // Interval of 5 idle cycles.
        ch_mask = 6'b000001; interval = 16'd5;
        enable = 1'b1;
        wait_words("t7_wait", 2, 300);
        stop_scan("t7_stop");
        check("t7_period",       32'(go_rise_q[1] - go_rise_q[0]), 32'(SETUP_CYC + CONV_DLY + 3 + 5));
        check("t7_accept_to_go", 32'(go_rise_q[1] - acc_q[0]),    32'd9);
        interval = '0;
        clear_q();

        // Asynchronous reset during CONV.
        ch_mask = 6'b000100; range_sel = 1'b1;
        enable = 1'b1;
        ok = 0;
        while (!ad_go && ok < 50) begin
            tick(1);
            ok++;
        end
        tick(3);
        #2 rst_n = 1'b0;
        #1;
        check("rconv_ad_go",    32'(ad_go),    32'd0);
        check("rconv_a_sel",    32'(a_sel),    32'd0);
        check("rconv_range",    32'(range),    32'd0);
        check("rconv_sgl",      32'(sgl_difn), 32'd1);
        check("rconv_busy",     32'(busy),     32'd0);
        check("rconv_out_data", out_data,      32'd0);
        enable = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        clear_q();

        // Asynchronous reset during PUSH: the word is dropped.
        out_ready = 1'b0;
        enable = 1'b1;
        ok = 0;
        while (!out_valid && ok < 100) begin
            tick(1);
            ok++;
        end
        check("rpush_reached", 32'(out_valid), 32'd1);
        tick(2);
        #2 rst_n = 1'b0;
        #1;
        check("rpush_valid",    32'(out_valid), 32'd0);
        check("rpush_out_data", out_data,       32'd0);
        check("rpush_busy",     32'(busy),      32'd0);
        enable = 1'b0; out_ready = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(20);
        check("rpush_no_word", 32'(got_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/ad7266_scan_ctrl.md
Name: ad7266_scan_ctrl

Overview:
- Channel sequencer for the AD7266 dual simultaneous-sampling ADC interface.
- Steps the mux address A2..A0 over an enabled channel mask and fires one conversion per channel.
- Captures the DATAA/DATAB pair and packs it with channel tags into a 32-bit word.
- Hands words to the downstream FIFO/mux over a valid/ready handshake, with a programmable inter-conversion interval and a conversion timeout.

Parameters:
- SETUP_CYC, 2: SCLK cycles the address/RANGE/SGL_DIFN are held stable before ad_go asserts (1..15).
- TIMEOUT_CYC, 64: max SCLK cycles in CONV waiting for ad_done before abort (2..255).
- NUM_CH, 6: channel pairs in single-ended mode (fixed at 6 for the AD7266).

Ports:
- SCLK  in  1  block clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  level; 1 = scan continuously.
- ch_mask  in  6  channel enable bits, bit n = channel n.
- range_sel  in  1  value driven onto range during a scan.
- diff_mode  in  1  1 = differential (channels 0..2 only).
- interval  in  16  idle SCLK cycles between conversions.
- ad_go  out  1  conversion request to the AD7266 interface.
- ad_done  in  1  conversion-complete strobe, 1 cycle.
- ad_dataa  in  16  A-side result; bits [11:0] used.
- ad_datab  in  16  B-side result; bits [11:0] used.
- a_sel  out  3  mux address {A2,A1,A0}.
- range  out  1  AD7266 RANGE pin.
- sgl_difn  out  1  AD7266 SGL/DIFN pin; 1 = single-ended.
- out_valid  out  1  packed word available.
- out_ready  in  1  downstream accepts the word.
- out_data  out  32  {ch[2:0],1'b0,dataa[11:0],ch[2:0],1'b1,datab[11:0]}.
- scan_done  out  1  1-cycle pulse after the last enabled channel of a scan is accepted.
- timeout_err  out  1  sticky; cleared when enable is low for ≥1 cycle.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values:
  - ad_go=0, a_sel=0, range=0, sgl_difn=1, out_valid=0, out_data=0.
  - scan_done=0, timeout_err=0, busy=0; FSM in IDLE.
  - Reset is asynchronous; asserting it mid-conversion or mid-handshake aborts immediately, with no word emitted.
- FSM states: IDLE, SETUP, CONV, PUSH, WAIT.
- IDLE:
  - Leaves when enable=1 and the effective mask ≠ 0.
  - Effective mask = ch_mask in single-ended mode; {3'b0,ch_mask[2:0]} when diff_mode=1.
  - On leaving, latch mask, range_sel and diff_mode; mid-scan input changes take effect at the next scan.
  - Select the lowest set bit → SETUP.
- SETUP:
  - Drive a_sel=channel, range, and sgl_difn=~diff_mode.
  - Count SETUP_CYC cycles, then → CONV.
- CONV:
  - ad_go=1 from the first CONV cycle until the cycle ad_done is sampled high.
  - ad_done high → capture [11:0] of both data buses; ad_go=0 next cycle → PUSH.
  - Timeout counter reaches TIMEOUT_CYC with no ad_done → ad_go=0, timeout_err=1, skip the channel (no word) → WAIT.
  - ad_done in the same cycle as the timeout expiry counts as success.
- PUSH:
  - out_valid=1 with out_data stable until out_valid&out_ready.
  - No further conversion starts while stalled, so no data is dropped.
  - On handshake: out_valid=0 next cycle → WAIT.
- WAIT:
  - Count interval cycles; interval=0 gives zero extra cycles.
  - Then advance to the next higher set bit in the latched mask, wrapping to the lowest set bit → SETUP.
  - On wrap, pulse scan_done for 1 cycle. With a single-bit mask, every accepted word pulses scan_done.
- enable deasserted mid-scan:
  - The current conversion and its PUSH complete; no new SETUP starts → IDLE.
  - scan_done is not pulsed for a partial scan.
- Interval counter is 16-bit with no wrap: max 65535 idle cycles.
- Latency, mask with one channel, interval=0, out_ready=1:
  - ad_go rises SETUP_CYC cycles after leaving IDLE.
  - out_valid rises 1 cycle after ad_done.
  - Back-to-back period = SETUP_CYC + conversion time + 3 cycles.
- ad_done outside CONV is ignored.

Test Plan:
- Reset, then enable=1, ch_mask=6'b000001, interval=0, ad_done returned 16 cycles after ad_go, ad_dataa=16'h0ABC, ad_datab=16'h0123, out_ready=1 → out_data=32'h0ABC_1123, a_sel=0, ad_go high exactly until ad_done, scan_done on every word.
- ch_mask=6'b101010 → a_sel sequence 1,3,5,1,…; channel tags in out_data match; scan_done only after the ch5 word is accepted.
- diff_mode=1, ch_mask=6'b111111 → only channels 0,1,2 scanned; sgl_difn=0; range tracks range_sel latched at scan start.
- ad_done never returned → ad_go drops after TIMEOUT_CYC=64 cycles, timeout_err=1, no out_valid, next channel proceeds; enable low for 1 cycle clears timeout_err.
- out_ready held low 50 cycles in PUSH → out_valid and out_data stable, ad_go stays low, word accepted on the first ready cycle, no data lost.
- rst_n asserted during CONV and during PUSH → all outputs return to reset values asynchronously; interval=5 verified as exactly 5 idle cycles between accept and the next SETUP.
